// File: rtl/ts_nibble_packetizer.sv
// ts_nibble_packetizer
// Drains a 4-bit TS FIFO (normal-mode read), pairs nibbles into bytes high
// nibble first, acquires and tracks MPEG-TS sync alignment, and emits aligned
// packets with start/end markers. Runs entirely in the FIFO read-clock domain.
//
// Ports
//   clk_i          FIFO read clock
//   rst_n_i        asynchronous active-low reset
//   fifo_q_i       FIFO read data, valid the cycle after fifo_rdreq_o
//   fifo_empty_i   FIFO read-side empty flag
//   fifo_rdreq_o   FIFO read request (combinational: run & ~empty)
//   byte_out_o     assembled packet byte
//   byte_valid_o   one-cycle qualifier for byte_out_o
//   pkt_start_o    with byte_valid_o: byte 0 of a packet
//   pkt_end_o      with byte_valid_o: last byte of a packet
//   sync_locked_o  high while in LOCKED
//   sync_err_o     one-cycle pulse on a failed sync check (VERIFY/LOCKED)
//   pkt_count_o    count of emitted packet ends, wraps at 16 bits

module ts_nibble_packetizer #(
    parameter int unsigned PKT_LEN   = 188,
    parameter logic [7:0]  SYNC_BYTE = 8'h47,
    parameter int unsigned LOCK_CNT  = 3,
    parameter int unsigned LOSS_CNT  = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [3:0]  fifo_q_i,
    input  logic        fifo_empty_i,
    output logic        fifo_rdreq_o,
    output logic [7:0]  byte_out_o,
    output logic        byte_valid_o,
    output logic        pkt_start_o,
    output logic        pkt_end_o,
    output logic        sync_locked_o,
    output logic        sync_err_o,
    output logic [15:0] pkt_count_o
);

    localparam int unsigned IW = $clog2(PKT_LEN);
    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam int unsigned MW = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e         state_q,  state_d;
    logic           run_q,    run_d;
    logic           nib_v_q,  nib_v_d;
    logic [7:0]     window_q, window_d;
    logic           low_q,    low_d;     // next accepted nibble is the low half
    logic [3:0]     hi_nib_q, hi_nib_d;
    logic [IW-1:0]  idx_q,    idx_d;     // index of the last completed byte
    logic [GW-1:0]  good_q,   good_d;
    logic [MW-1:0]  miss_q,   miss_d;
    logic [7:0]     byte_q,   byte_d;
    logic           valid_q,  valid_d;
    logic           start_q,  start_d;
    logic           end_q,    end_d;
    logic           locked_q, locked_d;
    logic           err_q,    err_d;
    logic [15:0]    count_q,  count_d;

    logic           rdreq_c;
    logic [7:0]     cur_byte;
    logic [IW-1:0]  cur_idx;
    logic [GW-1:0]  good_inc;
    logic [MW-1:0]  miss_inc;
    logic           hunt_clear;
    logic           emit_ok;

    // Read request: only once running and only when data is available
    assign rdreq_c      = run_q & ~fifo_empty_i;
    assign fifo_rdreq_o = rdreq_c;

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        run_d      = 1'b1;
        nib_v_d    = rdreq_c;
        window_d   = window_q;
        low_d      = low_q;
        hi_nib_d   = hi_nib_q;
        idx_d      = idx_q;
        good_d     = good_q;
        miss_d     = miss_q;
        byte_d     = byte_q;
        valid_d    = 1'b0;
        start_d    = 1'b0;
        end_d      = 1'b0;
        err_d      = 1'b0;
        count_d    = count_q;
        hunt_clear = 1'b0;
        emit_ok    = 1'b0;

        cur_byte = {hi_nib_q, fifo_q_i};
        cur_idx  = (idx_q == IW'(PKT_LEN - 1)) ? '0 : idx_q + IW'(1);
        good_inc = good_q + GW'(1);
        miss_inc = miss_q + MW'(1);

        if (nib_v_q) begin
            case (state_q)
                HUNT: begin
                    // Sliding nibble window: alignment may start on either half
                    window_d = {window_q[3:0], fifo_q_i};
                    if (window_d == SYNC_BYTE) begin
                        idx_d  = '0;
                        good_d = GW'(1);
                        miss_d = '0;
                        low_d  = 1'b0;
                        if (LOCK_CNT == 1) begin
                            state_d = LOCKED;
                            valid_d = 1'b1;
                            start_d = 1'b1;
                            byte_d  = window_d;
                        end else begin
                            state_d = VERIFY;
                        end
                    end
                end
                default: begin
                    if (!low_q) begin
                        hi_nib_d = fifo_q_i;
                        low_d    = 1'b1;
                    end else begin
                        low_d = 1'b0;
                        idx_d = cur_idx;
                        if (state_q == VERIFY) begin
                            // Count syncs silently until the lock threshold
                            if (cur_idx == '0) begin
                                if (cur_byte == SYNC_BYTE) begin
                                    good_d = good_inc;
                                    if (good_inc == GW'(LOCK_CNT)) begin
                                        state_d = LOCKED;
                                        valid_d = 1'b1;
                                        start_d = 1'b1;
                                        byte_d  = cur_byte;
                                    end
                                end else begin
                                    err_d      = 1'b1;
                                    hunt_clear = 1'b1;
                                end
                            end
                        end else begin
                            // Locked: flywheel over isolated sync misses
                            emit_ok = 1'b1;
                            if (cur_idx == '0) begin
                                if (cur_byte != SYNC_BYTE) begin
                                    err_d  = 1'b1;
                                    miss_d = miss_inc;
                                    if (miss_inc >= MW'(LOSS_CNT)) begin
                                        emit_ok    = 1'b0;
                                        hunt_clear = 1'b1;
                                    end
                                end else begin
                                    miss_d = '0;
                                end
                            end
                            if (emit_ok) begin
                                valid_d = 1'b1;
                                start_d = (cur_idx == '0);
                                end_d   = (cur_idx == IW'(PKT_LEN - 1));
                                byte_d  = cur_byte;
                                if (cur_idx == IW'(PKT_LEN - 1)) begin
                                    count_d = count_q + 16'd1;
                                end
                            end
                        end
                    end
                end
            endcase
        end

        // Loss of alignment restarts the hunt from an empty window
        if (hunt_clear) begin
            state_d  = HUNT;
            window_d = '0;
            idx_d    = '0;
            good_d   = '0;
            miss_d   = '0;
            low_d    = 1'b0;
        end

        locked_d = (state_d == LOCKED);
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= HUNT;
            run_q    <= 1'b0;
            nib_v_q  <= 1'b0;
            window_q <= '0;
            low_q    <= 1'b0;
            hi_nib_q <= '0;
            idx_q    <= '0;
            good_q   <= '0;
            miss_q   <= '0;
            byte_q   <= '0;
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            end_q    <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            nib_v_q  <= nib_v_d;
            window_q <= window_d;
            low_q    <= low_d;
            hi_nib_q <= hi_nib_d;
            idx_q    <= idx_d;
            good_q   <= good_d;
            miss_q   <= miss_d;
            byte_q   <= byte_d;
            valid_q  <= valid_d;
            start_q  <= start_d;
            end_q    <= end_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            count_q  <= count_d;
        end
    end

    assign byte_out_o    = byte_q;
    assign byte_valid_o  = valid_q;
    assign pkt_start_o   = start_q;
    assign pkt_end_o     = end_q;
    assign sync_locked_o = locked_q;
    assign sync_err_o    = err_q;
    assign pkt_count_o   = count_q;

endmodule
